// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared definitions for the decoder scan sequencer: state encoding,
// the decoder select bit-reversal and the number of decoded lines.
package scan_pkg;

  localparam int LINES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } scan_state_e;

  // The downstream decoder expects its select bits in reversed order
  // relative to the natural line index.
  function automatic logic [1:0] bitrev2(input logic [1:0] v);
    return {v[0], v[1]};
  endfunction

endpackage

// File: rtl/decoder_scan_ctrl_next_line_pick.sv
// Rotating-priority line picker: finds the first mask bit strictly above
// cur_idx (modulo 4). Falls back to cur_idx itself when it is the only set
// bit. wrap flags that the pick did not move to a higher index.
module next_line_pick
  import scan_pkg::*;
(
  input  logic [1:0] cur_idx,
  input  logic [3:0] mask,
  output logic [1:0] nxt_idx,
  output logic       wrap
);

  logic       found;
  logic [1:0] cand;

  // Search cur+1, cur+2, cur+3, cur+4(=cur) and keep the first hit.
  always_comb begin
    nxt_idx = cur_idx;
    found   = 1'b0;
    cand    = cur_idx;
    for (int i = 1; i <= LINES; i++) begin
      cand = cur_idx + 2'(i);
      if (!found && mask[cand]) begin
        nxt_idx = cand;
        found   = 1'b1;
      end
    end
    wrap = found && (nxt_idx <= cur_idx);
  end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer feeding a 2-to-4 line decoder. Lines in line_mask are
// enabled one at a time in round-robin order, each held for DWELL_CYCLES
// with an en-low gap of BLANK_CYCLES between lines.
//
//   state  | meaning
//   IDLE   | not scanning, en low, waiting for run with a non-empty mask
//   ACTIVE | selected line driven, en high, dwell counter running
//   BLANK  | en low, din/line_idx held, blank counter running
module decoder_scan_ctrl
  import scan_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] line_mask,
  output logic [1:0] din,
  output logic       en,
  output logic [1:0] line_idx,
  output logic       frame_done
);

  localparam logic             NO_BLANK   = (BLANK_CYCLES == 0);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = NO_BLANK ? '0 : CNT_W'(BLANK_CYCLES - 1);

  scan_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  logic [1:0]       din_q;
  logic             en_q;
  logic             fd_q;

  logic [1:0]       pick_cur_d;
  logic [1:0]       pick_idx_d;
  logic             pick_wrap_d;
  logic             leave_dwell_d;
  logic             gap_end_d;

  // From IDLE the search starts just above line 3, so the picker returns
  // the lowest set bit of the mask; otherwise it rotates from the current line.
  assign pick_cur_d = (state_q == IDLE) ? 2'd3 : idx_q;

  next_line_pick u_pick (
    .cur_idx (pick_cur_d),
    .mask    (line_mask),
    .nxt_idx (pick_idx_d),
    .wrap    (pick_wrap_d)
  );

  // Dwell ends on terminal count or early when run drops.
  assign leave_dwell_d = (state_q == ACTIVE) && (!run || (cnt_q == '0));

  // End of the blank gap; with no gap configured it coincides with the dwell end.
  assign gap_end_d = ((state_q == BLANK) && (cnt_q == '0)) ||
                     (leave_dwell_d && NO_BLANK);

  // Sequencer state, counter and all registered decoder-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      din_q   <= 2'b00;
      en_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      if (gap_end_d) begin
        if (!run || (line_mask == 4'b0000)) begin
          state_q <= IDLE;
          en_q    <= 1'b0;
          cnt_q   <= '0;
        end else begin
          state_q <= ACTIVE;
          idx_q   <= pick_idx_d;
          din_q   <= bitrev2(pick_idx_d);
          en_q    <= 1'b1;
          cnt_q   <= DWELL_LOAD;
          fd_q    <= pick_wrap_d;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (run && (line_mask != 4'b0000)) begin
              state_q <= ACTIVE;
              idx_q   <= pick_idx_d;
              din_q   <= bitrev2(pick_idx_d);
              en_q    <= 1'b1;
              cnt_q   <= DWELL_LOAD;
            end
          end
          ACTIVE: begin
            if (leave_dwell_d) begin
              state_q <= BLANK;
              en_q    <= 1'b0;
              cnt_q   <= BLANK_LOAD;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          BLANK: begin
            cnt_q <= cnt_q - 1'b1;
          end
          default: begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign din        = din_q;
  assign en         = en_q;
  assign line_idx   = idx_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl with DWELL=4, BLANK=2. The reference model
// tracks each line by its age since entry and the total line length
// (dwell + blank), deciding line changes from the selection rules directly.
module tb_decoder_scan_ctrl;

  localparam int DWELL = 4;
  localparam int BLANK = 2;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [3:0] line_mask;
  logic [1:0] din;
  logic       en;
  logic [1:0] line_idx;
  logic       frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  decoder_scan_ctrl #(
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK),
    .CNT_W        (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .line_mask  (line_mask),
    .din        (din),
    .en         (en),
    .line_idx   (line_idx),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic       m_scan;
  logic [1:0] m_idx;
  logic       m_en;
  logic       m_fd;
  int         m_age;
  int         m_dlen;
  logic [1:0] m_din;

  assign m_din = {m_idx[0], m_idx[1]};

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 3; k >= 0; k--) if (m[k]) r = 2'(k);
    return r;
  endfunction

  function automatic logic [1:0] next_after(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] r;
    r = cur;
    for (int k = 4; k >= 1; k--) if (m[(int'(cur) + k) % 4]) r = 2'((int'(cur) + k) % 4);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [1:0] old;
    if (!rst_n) begin
      m_scan = 1'b0; m_idx = 2'd0; m_en = 1'b0; m_fd = 1'b0;
      m_age = 0; m_dlen = DWELL;
    end else begin
      m_fd = 1'b0;
      if (!m_scan) begin
        if (run && line_mask != 4'b0000) begin
          m_idx = lowest_set(line_mask);
          m_scan = 1'b1; m_age = 0; m_dlen = DWELL; m_en = 1'b1;
        end
      end else begin
        if (m_age < m_dlen && !run) m_dlen = m_age + 1;
        if (m_age + 1 == m_dlen + BLANK) begin
          if (!run || line_mask == 4'b0000) begin
            m_scan = 1'b0; m_en = 1'b0;
          end else begin
            old = m_idx;
            m_idx = next_after(old, line_mask);
            m_fd = (m_idx <= old);
            m_age = 0; m_dlen = DWELL; m_en = 1'b1;
          end
        end else begin
          m_age = m_age + 1;
          m_en = (m_age < m_dlen);
        end
      end
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    run = 1'b0;
    for (int i = 0; i < 30 && (m_scan || en); i++) tick();
    n_cmp++;
    if (m_scan || en) begin
      n_bad++;
      $display("FAIL go_idle_timeout: en=%0b model_scan=%0b, want both 0", en, m_scan);
    end
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; line_mask = 4'b0000;
    #12;
    n_cmp++;
    if ({en, din, line_idx, frame_done} !== 6'b0_00_00_0) begin
      n_bad++;
      $display("FAIL reset_outputs: got en=%0b din=%b idx=%0d fd=%0b, want 0/00/0/0",
               en, din, line_idx, frame_done);
    end
    rst_n = 1'b1;
    tick(); tick();
    n_cmp++;
    if (en !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle_no_run: got en=%0b want 0", en);
    end
  endtask

  task automatic test_pattern(input string name, input logic [3:0] msk, input logic [7:0] seq,
                              input int seq_len, input int period, input int ncyc);
    int fd_t[$];
    logic [1:0] ent[$];
    logic prev_en;
    logic [1:0] exp_d;
    go_idle();
    line_mask = msk; run = 1'b1;
    prev_en = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      n_cmp++;
      if ({en, din, line_idx, frame_done} !== {m_en, m_din, m_idx, m_fd}) begin
        n_bad++;
        $display("FAIL %s_model c=%0d: got en=%0b din=%b idx=%0d fd=%0b, want en=%0b din=%b idx=%0d fd=%0b",
                 name, c, en, din, line_idx, frame_done, m_en, m_din, m_idx, m_fd);
      end
      if (frame_done) fd_t.push_back(c);
      if (en && !prev_en) ent.push_back(din);
      prev_en = en;
    end
    n_cmp++;
    if (fd_t.size() != (ncyc - 1) / period) begin
      n_bad++;
      $display("FAIL %s_fd_count: got %0d want %0d", name, fd_t.size(), (ncyc - 1) / period);
    end
    foreach (fd_t[i]) begin
      n_cmp++;
      if (fd_t[i] != (i + 1) * period) begin
        n_bad++;
        $display("FAIL %s_fd_time[%0d]: got %0d want %0d", name, i, fd_t[i], (i + 1) * period);
      end
    end
    n_cmp++;
    if (ent.size() != ncyc / (DWELL + BLANK) + ((ncyc % (DWELL + BLANK)) != 0 ? 1 : 0)) begin
      n_bad++;
      $display("FAIL %s_entry_count: got %0d", name, ent.size());
    end
    foreach (ent[i]) begin
      exp_d = seq[7 - 2 * (i % seq_len) -: 2];
      n_cmp++;
      if (ent[i] !== exp_d) begin
        n_bad++;
        $display("FAIL %s_din_seq[%0d]: got %b want %b", name, i, ent[i], exp_d);
      end
    end
  endtask

  task automatic test_run_drop();
    int highs;
    go_idle();
    line_mask = 4'b1111; run = 1'b1;
    tick(); tick();
    n_cmp++;
    if (en !== 1'b1) begin
      n_bad++;
      $display("FAIL run_drop_pre: got en=%0b want 1", en);
    end
    run = 1'b0;
    tick();
    n_cmp++;
    if (en !== 1'b0) begin
      n_bad++;
      $display("FAIL run_drop_en: got en=%0b want 0", en);
    end
    highs = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (en) highs++;
      n_cmp++;
      if ({en, din, line_idx, frame_done} !== {m_en, m_din, m_idx, m_fd}) begin
        n_bad++;
        $display("FAIL run_drop_model c=%0d: got en=%0b din=%b, want en=%0b din=%b",
                 c, en, din, m_en, m_din);
      end
    end
    n_cmp++;
    if (highs != 0) begin
      n_bad++;
      $display("FAIL run_drop_no_pulse: got %0d en-high cycles want 0", highs);
    end
  endtask

  task automatic test_async_reset();
    go_idle();
    line_mask = 4'b1111; run = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    n_cmp++;
    if ({en, din} !== 3'b1_10) begin
      n_bad++;
      $display("FAIL areset_pre: got en=%0b din=%b want en=1 din=10", en, din);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({en, din, line_idx, frame_done} !== 6'b0_00_00_0) begin
      n_bad++;
      $display("FAIL areset_immediate: got en=%0b din=%b idx=%0d fd=%0b want 0/00/0/0",
               en, din, line_idx, frame_done);
    end
    line_mask = 4'b1100;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({en, din, line_idx} !== 5'b1_01_10) begin
      n_bad++;
      $display("FAIL areset_restart: got en=%0b din=%b idx=%0d want en=1 din=01 idx=2",
               en, din, line_idx);
    end
  endtask

  task automatic test_mask_change();
    logic [1:0] ent_idx[$];
    logic       ent_fd[$];
    logic prev_en;
    go_idle();
    line_mask = 4'b1111; run = 1'b1;
    for (int i = 0; i < 20 && !(en && line_idx == 2'd1); i++) tick();
    n_cmp++;
    if (!(en && line_idx == 2'd1)) begin
      n_bad++;
      $display("FAIL mask_chg_reach_line1: got en=%0b idx=%0d want en=1 idx=1", en, line_idx);
    end
    line_mask = 4'b1001;
    prev_en = 1'b1;
    for (int c = 0; c < 16; c++) begin
      tick();
      n_cmp++;
      if ({en, din, line_idx, frame_done} !== {m_en, m_din, m_idx, m_fd}) begin
        n_bad++;
        $display("FAIL mask_chg_model c=%0d: got en=%0b idx=%0d fd=%0b want en=%0b idx=%0d fd=%0b",
                 c, en, line_idx, frame_done, m_en, m_idx, m_fd);
      end
      if (en && !prev_en) begin
        ent_idx.push_back(line_idx);
        ent_fd.push_back(frame_done);
      end
      prev_en = en;
    end
    n_cmp++;
    if (ent_idx.size() < 2) begin
      n_bad++;
      $display("FAIL mask_chg_entries: got %0d want >=2", ent_idx.size());
    end else begin
      n_cmp++;
      if (ent_idx[0] !== 2'd3 || ent_fd[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL mask_chg_first: got idx=%0d fd=%0b want idx=3 fd=0", ent_idx[0], ent_fd[0]);
      end
      n_cmp++;
      if (ent_idx[1] !== 2'd0 || ent_fd[1] !== 1'b1) begin
        n_bad++;
        $display("FAIL mask_chg_second: got idx=%0d fd=%0b want idx=0 fd=1", ent_idx[1], ent_fd[1]);
      end
    end
  endtask

  task automatic test_random();
    go_idle();
    line_mask = 4'($urandom_range(1, 15)); run = 1'b1;
    for (int c = 0; c < 800; c++) begin
      tick();
      n_cmp++;
      if ({en, din, line_idx, frame_done} !== {m_en, m_din, m_idx, m_fd}) begin
        n_bad++;
        $display("FAIL random_model c=%0d: got en=%0b din=%b idx=%0d fd=%0b, want en=%0b din=%b idx=%0d fd=%0b",
                 c, en, din, line_idx, frame_done, m_en, m_din, m_idx, m_fd);
      end
      if ($urandom_range(0, 9) == 0) run = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) line_mask = 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    test_reset();
    test_pattern("all_lines", 4'b1111, 8'b00_10_01_11, 4, 24, 60);
    test_pattern("mask_1010", 4'b1010, 8'b10_11_00_00, 2, 12, 40);
    test_pattern("single",    4'b0100, 8'b01_00_00_00, 1, 6, 30);
    test_run_drop();
    test_async_reset();
    test_mask_change();
    test_random();
    go_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
